// File: rtl/hazard_ctl.sv
// hazard_ctl: pipeline hazard control for a five-stage core.
// Load-use and mult/div stalls, branch flush, ME->EX forwarding, stall counter.
module hazard_ctl #(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  Rs_IF,
   input  logic [4:0]  Rt_IF,
   input  logic        UsesHiLo_IF,
   input  logic [1:0]  MulDiv_IF,
   input  logic [4:0]  Rs_ID,
   input  logic [4:0]  Rt_ID,
   input  logic        MemToReg_ID,
   input  logic        RegWrite_ME,
   input  logic [4:0]  WriteReg_ME,
   input  logic        BranchTaken_EX,
   input  logic        MemBusy_ME,
   output logic        AnyStall,
   output logic        flush,
   output logic        FwdA_EX,
   output logic        FwdB_EX,
   output logic        MulDivBusy,
   output logic [31:0] StallCnt
);

   localparam logic [5:0] LP_MULT = 6'(MULT_CYCLES);
   localparam logic [5:0] LP_DIV  = 6'(DIV_CYCLES);

   logic [5:0]  r_busy_cnt;
   logic        r_lu_done;
   logic        r_flush_q;
   logic [31:0] r_stall_cnt;

   logic w_load_use;
   logic w_is_mult;
   logic w_is_div;
   logic w_busy;
   logic w_md_haz;
   logic w_stall;
   logic w_md_start;

   // Hazard detection and forwarding selects
   always_comb begin
      w_is_mult  = (MulDiv_IF == 2'b01);
      w_is_div   = (MulDiv_IF == 2'b10);
      w_busy     = (r_busy_cnt != 6'd0);
      w_load_use = MemToReg_ID & (Rt_ID != 5'd0)
                 & ((Rt_ID == Rs_IF) | (Rt_ID == Rt_IF))
                 & ~r_lu_done;
      w_md_haz   = w_busy & (UsesHiLo_IF | w_is_mult | w_is_div);
      w_stall    = reset_n & (w_load_use | w_md_haz | MemBusy_ME);
      w_md_start = ~w_busy & ~w_stall & ~r_flush_q;
      FwdA_EX    = RegWrite_ME & (WriteReg_ME != 5'd0)
                 & (WriteReg_ME == Rs_ID);
      FwdB_EX    = RegWrite_ME & (WriteReg_ME != 5'd0)
                 & (WriteReg_ME == Rt_ID);
   end

   // Load-use bubble is one cycle: remember it was inserted
   always_ff @(posedge clk) begin
      if (!reset_n)
         r_lu_done <= 1'b0;
      else if (!w_stall)
         r_lu_done <= 1'b0;
      else if (w_load_use)
         r_lu_done <= 1'b1;
   end

   // Mult/div occupancy counter; drains even while stalled
   always_ff @(posedge clk) begin
      if (!reset_n)
         r_busy_cnt <= 6'd0;
      else if (w_md_start && w_is_mult)
         r_busy_cnt <= LP_MULT;
      else if (w_md_start && w_is_div)
         r_busy_cnt <= LP_DIV;
      else if (w_busy)
         r_busy_cnt <= r_busy_cnt - 6'd1;
   end

   // Taken branch produces a flush pulse only once no stall holds it off
   always_ff @(posedge clk) begin
      if (!reset_n)
         r_flush_q <= 1'b1;
      else
         r_flush_q <= BranchTaken_EX & ~w_stall;
   end

   // Saturating count of stalled cycles
   always_ff @(posedge clk) begin
      if (!reset_n)
         r_stall_cnt <= 32'd0;
      else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign AnyStall   = w_stall;
   assign flush      = r_flush_q;
   assign MulDivBusy = w_busy;
   assign StallCnt   = r_stall_cnt;

endmodule

// File: doc/hazard_ctl.md
HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 4, EX-occupancy cycles of a mult.
REQ-002 SHALL have parameter DIV_CYCLES, default 32, EX-occupancy cycles of a div.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports Rs_IF, Rt_IF  in  5 each  source fields [25:21]/[20:16] of the instruction in decode.
REQ-006 SHALL have port UsesHiLo_IF  in  1  decode instruction is mfhi/mflo.
REQ-007 SHALL have port MulDiv_IF  in  2  decode instruction class: 00 none, 01 mult, 10 div, 11 treated as 00.
REQ-008 SHALL have ports Rs_ID, Rt_ID  in  5 each  source/target registers of the instruction in EX.
REQ-009 SHALL have port MemToReg_ID  in  1  instruction in EX is a load, destination Rt_ID.
REQ-010 SHALL have ports RegWrite_ME  in  1, WriteReg_ME  in  5  ME-stage writeback enable and destination.
REQ-011 SHALL have port BranchTaken_EX  in  1  branch resolved taken in EX this cycle.
REQ-012 SHALL have port MemBusy_ME  in  1  data memory not ready.
REQ-013 SHALL have port AnyStall  out  1  hold decode pipeline registers, block regfile write.
REQ-014 SHALL have port flush  out  1  registered clear pulse for decode pipeline registers.
REQ-015 SHALL have ports FwdA_EX, FwdB_EX  out  1 each  select ME result instead of RdDatA_ID/RdDatB_ID.
REQ-016 SHALL have port MulDivBusy  out  1  mult/div unit occupied.
REQ-017 SHALL have port StallCnt  out  32  count of stalled cycles.

Function
REQ-018 State: busy_cnt (6 bits), lu_done (1), flush_q (1), StallCnt (32).
REQ-019 LoadUse = MemToReg_ID & Rt_ID!=0 & (Rt_ID==Rs_IF | Rt_ID==Rt_IF) & !lu_done.
REQ-020 MdHaz = busy_cnt!=0 & (UsesHiLo_IF | MulDiv_IF==01 | MulDiv_IF==10).
REQ-021 AnyStall SHALL be combinational = reset_n & (LoadUse | MdHaz | MemBusy_ME).
REQ-022 lu_done SHALL set at the edge where LoadUse & AnyStall, and clear at any edge where AnyStall=0, so a load-use bubble lasts exactly one cycle unless other stall terms extend it.
REQ-023 busy_cnt SHALL load MULT_CYCLES (01) or DIV_CYCLES (10) when busy_cnt==0, AnyStall=0, flush_q=0; otherwise decrement by 1 when nonzero, independent of AnyStall; never wraps below 0.
REQ-024 MulDivBusy SHALL equal busy_cnt!=0; busy from the cycle after start for exactly the configured count.
REQ-025 flush_q SHALL load BranchTaken_EX & !AnyStall each edge; flush=flush_q, one-cycle pulse per taken branch; back-to-back taken branches give back-to-back pulses.
REQ-026 Taken branch coincident with AnyStall=1 SHALL be held off: no flush until the stall clears and BranchTaken_EX is still high.
REQ-027 FwdA_EX SHALL = RegWrite_ME & WriteReg_ME!=0 & WriteReg_ME==Rs_ID; FwdB_EX likewise with Rt_ID; combinational, unaffected by stall/flush.
REQ-028 StallCnt SHALL increment on each edge with AnyStall=1, saturating at 32'hFFFFFFFF.
REQ-029 Register 0 SHALL never cause a stall or forward.

Reset
REQ-030 While reset_n=0 at an edge: busy_cnt=0, lu_done=0, StallCnt=0, flush_q=1.
REQ-031 AnyStall SHALL be 0 whenever reset_n=0; flush SHALL be 1 through the first edge after reset_n rises.
REQ-032 Reset mid mult/div SHALL abort it: MulDivBusy=0 the cycle after.

Verification
REQ-033 lw $2 in EX (MemToReg_ID=1, Rt_ID=2), Rs_IF=2 -> AnyStall=1 one cycle, then 0 with inputs held; StallCnt=1.
REQ-034 div start (MulDiv_IF=10), then mflo at decode -> MulDivBusy high 32 cycles, AnyStall high until busy_cnt=0, no second load.
REQ-035 BranchTaken_EX=1 one cycle, no stall -> flush=1 exactly the next cycle; with MemBusy_ME=1 -> flush deferred until MemBusy_ME=0.
REQ-036 RegWrite_ME=1, WriteReg_ME=5, Rs_ID=5, Rt_ID=0 -> FwdA_EX=1, FwdB_EX=0; WriteReg_ME=0 -> both 0.
REQ-037 reset_n=0 during mult (busy_cnt=2) -> next cycle MulDivBusy=0, StallCnt=0, flush=1, AnyStall=0.
REQ-038 MemBusy_ME held 1 with StallCnt preset to 32'hFFFFFFFE -> counts to FFFFFFFF and holds.
